// File: rtl/mandelbrot_frame_scheduler.sv
// Frame sweep controller: walks a WIDTH x HEIGHT grid, hands Q3.29 coordinates to a
// pool of point engines and streams their iteration counts out tagged with pixel address.
module mandelbrot_frame_scheduler #(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter int unsigned N_ENGINES = 4,
  parameter int unsigned ADDR_W    = 19
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [31:0]               x_min,
  input  logic [31:0]               y_max,
  input  logic [31:0]               step,
  input  logic [31:0]               max_iterations,
  output logic                      busy,
  output logic                      frame_done,
  output logic [N_ENGINES-1:0]      eng_req,
  input  logic [N_ENGINES-1:0]      eng_ack,
  input  logic [N_ENGINES-1:0]      eng_done,
  input  logic [N_ENGINES*10-1:0]   eng_iter,
  output logic [N_ENGINES*32-1:0]   eng_x,
  output logic [N_ENGINES*32-1:0]   eng_y,
  output logic [31:0]               eng_max_iterations,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [ADDR_W-1:0]         pix_addr,
  output logic [9:0]                pix_count
);
  localparam int unsigned COORD_W = 32;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned IDX_W   = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam int unsigned COL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]           state, next_state;
  logic [COORD_W-1:0]   x_min_q, step_q, cx, cy;
  logic [COL_W-1:0]     col;
  logic [ADDR_W-1:0]    addr;
  logic [N_ENGINES-1:0] in_flight, slot_valid;
  logic [ADDR_W-1:0]    held_addr  [N_ENGINES];
  logic [ADDR_W-1:0]    slot_addr  [N_ENGINES];
  logic [CNT_W-1:0]     slot_count [N_ENGINES];
  logic [IDX_W-1:0]     rr_ptr, pix_sel;

  logic                 disp_c;
  logic [IDX_W-1:0]     disp_idx_c;
  logic [N_ENGINES-1:0] ack_vec_c;
  logic [N_ENGINES-1:0] cand_c;
  logic                 grant_c;
  logic [IDX_W-1:0]     grant_idx_c;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return (v >= int'(N_ENGINES)) ? IDX_W'(v - int'(N_ENGINES)) : IDX_W'(v);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state, dispatch pick (lowest free engine) and round-robin output grant.
  always_comb begin
    next_state  = state;
    disp_c      = 1'b0;
    disp_idx_c  = '0;
    grant_c     = 1'b0;
    grant_idx_c = '0;
    ack_vec_c   = eng_req & eng_ack;
    cand_c      = slot_valid;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if ((|ack_vec_c) && (addr == LAST_ADDR)) next_state = DRAIN;
      DRAIN:   if ((in_flight == '0) && (slot_valid == '0)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Only one request outstanding: the cursor has not advanced until it is acked.
    if ((state == RUN) && (eng_req == '0)) begin
      for (int i = int'(N_ENGINES) - 1; i >= 0; i--) begin
        if (!in_flight[i] && !slot_valid[i]) begin
          disp_c     = 1'b1;
          disp_idx_c = IDX_W'(i);
        end
      end
    end
    if (pix_valid) cand_c[pix_sel] = 1'b0;
    if (!pix_valid || pix_ready) begin
      for (int k = int'(N_ENGINES) - 1; k >= 0; k--) begin
        if (cand_c[wrap_idx(int'(rr_ptr) + k)]) begin
          grant_c     = 1'b1;
          grant_idx_c = wrap_idx(int'(rr_ptr) + k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      eng_req            <= '0;
      eng_x              <= '0;
      eng_y              <= '0;
      eng_max_iterations <= '0;
      pix_valid          <= 1'b0;
      pix_addr           <= '0;
      pix_count          <= '0;
      x_min_q            <= '0;
      step_q             <= '0;
      cx                 <= '0;
      cy                 <= '0;
      col                <= '0;
      addr               <= '0;
      in_flight          <= '0;
      slot_valid         <= '0;
      rr_ptr             <= '0;
      pix_sel            <= '0;
      for (int i = 0; i < int'(N_ENGINES); i++) begin
        held_addr[i]  <= '0;
        slot_addr[i]  <= '0;
        slot_count[i] <= '0;
      end
    end else begin
      busy       <= (next_state != IDLE);
      frame_done <= (state == DRAIN) && (next_state == IDLE);
      if ((state == IDLE) && start) begin
        x_min_q            <= x_min;
        step_q             <= step;
        eng_max_iterations <= max_iterations;
        cx                 <= x_min;
        cy                 <= y_max;
        col                <= '0;
        addr               <= '0;
      end
      if (disp_c) begin
        eng_req[disp_idx_c]                          <= 1'b1;
        eng_x[int'(disp_idx_c) * COORD_W +: COORD_W] <= cx;
        eng_y[int'(disp_idx_c) * COORD_W +: COORD_W] <= cy;
        held_addr[disp_idx_c]                        <= addr;
      end
      for (int i = 0; i < int'(N_ENGINES); i++) begin
        if (ack_vec_c[i]) begin
          eng_req[i]   <= 1'b0;
          in_flight[i] <= 1'b1;
        end
        if (eng_done[i] && in_flight[i]) begin
          in_flight[i]  <= 1'b0;
          slot_valid[i] <= 1'b1;
          slot_addr[i]  <= held_addr[i];
          slot_count[i] <= eng_iter[i * CNT_W +: CNT_W];
        end
      end
      // Pixel cursor: raster order, coordinates wrap in two's complement.
      if (|ack_vec_c) begin
        if (col == LAST_COL) begin
          col <= '0;
          cx  <= x_min_q;
          cy  <= cy - step_q;
        end else begin
          col <= col + COL_W'(1);
          cx  <= cx + step_q;
        end
        addr <= addr + ADDR_W'(1);
      end
      if (pix_valid && pix_ready) begin
        slot_valid[pix_sel] <= 1'b0;
        pix_valid           <= 1'b0;
      end
      if (grant_c) begin
        pix_valid <= 1'b1;
        pix_addr  <= slot_addr[grant_idx_c];
        pix_count <= slot_count[grant_idx_c];
        pix_sel   <= grant_idx_c;
        rr_ptr    <= wrap_idx(int'(grant_idx_c) + 1);
      end
    end
  end
endmodule
